abcd_seq_controller: RTL and testbench

//  Sequencing controller for the 4-bit {a,b,c,d} D-flip-flop state register of the team's sequential circuits.

---
 rtl/abcd_seq_controller.sv | 176 +++++++++++++++++
 tb/tb_abcd_seq_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/abcd_seq_controller.sv
// abcd_seq_controller: sequencing controller for the 4-bit {a,b,c,d} state
// register. The excitation logic is external and delivers the next state on
// next_in. This block decides when the register captures it: free-run,
// single-step with a 4-phase handshake, or parallel load. It also detects the
// terminal state and counts captures.
//
// Build option: define SEQ_WATCHDOG_EN to end a free-run in DONE with
// timeout=1 once MAX_STEPS captures happen without reaching TERM_STATE.
// Without it no watchdog logic is built and timeout is tied low.
module abcd_seq_controller #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TERM_STATE = {WIDTH{1'b1}},
    parameter int               CNT_W      = 8,
    parameter int               MAX_STEPS  = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step_req,
    output logic             step_ack,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] next_in,
    output logic [WIDTH-1:0] state_out,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_DONE     = 3'd4
    } fsm_t;

    // A watchdog limit of zero would end every run before its first capture.
    if (MAX_STEPS < 1) begin : g_bad_max_steps
        $error("abcd_seq_controller: MAX_STEPS must be at least 1");
    end

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] sv_q, sv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ack_q, ack_d;
    logic             running_q, done_q;

`ifdef SEQ_WATCHDOG_EN
    localparam int RW = $clog2(MAX_STEPS + 1);
    logic [RW-1:0] run_cnt_q, run_cnt_d, run_inc;
    logic          to_q, to_d;

    assign run_inc = run_cnt_q + RW'(1);
`endif

    // Capture counter saturates at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and datapath decisions for every FSM state.
    always_comb begin
        fsm_d = fsm_q;
        sv_d  = sv_q;
        cnt_d = cnt_q;
        ack_d = ack_q;
`ifdef SEQ_WATCHDOG_EN
        run_cnt_d = run_cnt_q;
        to_d      = to_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (load) begin
                    sv_d  = load_val;
                    cnt_d = '0;
                end else if (start) begin
                    fsm_d = S_RUN;
`ifdef SEQ_WATCHDOG_EN
                    run_cnt_d = '0;
`endif
                end else if (step_req) begin
                    fsm_d = S_STEP;
                end
            end
            S_RUN: begin
                if (stop) begin
                    fsm_d = S_IDLE;
                end else begin
                    sv_d  = next_in;
                    cnt_d = cnt_inc;
`ifdef SEQ_WATCHDOG_EN
                    run_cnt_d = run_inc;
`endif
                    if (next_in == TERM_STATE) begin
                        fsm_d = S_DONE;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (run_inc == RW'(MAX_STEPS)) begin
                        fsm_d = S_DONE;
                        to_d  = 1'b1;
                    end
`endif
                end
            end
            S_STEP: begin
                sv_d  = next_in;
                cnt_d = cnt_inc;
                ack_d = 1'b1;
                fsm_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                // Only the release ends the handshake, so a held request
                // never causes a second capture.
                if (!step_req) begin
                    ack_d = 1'b0;
                    fsm_d = (sv_q == TERM_STATE) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (load) begin
                    sv_d  = load_val;
                    cnt_d = '0;
                    fsm_d = S_IDLE;
`ifdef SEQ_WATCHDOG_EN
                    to_d = 1'b0;
`endif
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // State and output registers; clear_n aborts any activity immediately.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            fsm_q     <= S_IDLE;
            sv_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            sv_q      <= sv_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            running_q <= (fsm_d == S_RUN);
            done_q    <= (fsm_d == S_DONE);
        end
    end

`ifdef SEQ_WATCHDOG_EN
    // Per-run capture count and the timeout flag.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            run_cnt_q <= '0;
            to_q      <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            to_q      <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign state_out = sv_q;
    assign step_cnt  = cnt_q;
    assign step_ack  = ack_q;
    assign running   = running_q;
    assign done      = done_q;

endmodule

// File: tb/tb_abcd_seq_controller.sv
// Directed bench for abcd_seq_controller. The excitation logic is modelled as
// next_in = state_out + 1 unless a scenario overrides next_in.
module tb_abcd_seq_controller;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start, stop, step_req, load;
    logic       step_ack, running, done, timeout;
    logic [3:0] load_val, next_in, state_out;
    logic [7:0] step_cnt;
    logic       ovr;
    logic [3:0] ovr_val;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign next_in = ovr ? ovr_val : state_out + 4'd1;

    abcd_seq_controller dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .stop      (stop),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .load      (load),
        .load_val  (load_val),
        .next_in   (next_in),
        .state_out (state_out),
        .running   (running),
        .done      (done),
        .timeout   (timeout),
        .step_cnt  (step_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        clear_n = 1'b0; start = 0; stop = 0; step_req = 0; load = 0;
        load_val = '0; ovr = 0; ovr_val = '0;

        // Reset state before any clock edge
        #2;
        chk("rst_state", state_out, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", step_ack, 0);
        chk("rst_cnt", step_cnt, 0);
        chk("rst_timeout", timeout, 0);
        tick();
        clear_n = 1'b1;

        // Priority: load beats start, then start alone enters RUN without capture
        load = 1; load_val = 4'hA; start = 1;
        tick();
        chk("prio_state", state_out, 4'hA);
        chk("prio_idle", running, 0);
        load = 0;
        tick();
        chk("prio_run", running, 1);
        chk("prio_nocap", state_out, 4'hA);
        start = 0; stop = 1;
        tick();
        chk("stop0_running", running, 0);
        chk("stop0_state", state_out, 4'hA);
        stop = 0;

        // Free run from 3: twelve captures 4..F
        load = 1; load_val = 4'h3;
        tick();
        chk("run_load", state_out, 4'h3);
        chk("run_load_cnt", step_cnt, 0);
        load = 0; start = 1;
        tick();
        start = 0;
        chk("run_entered", running, 1);
        repeat (11) tick();
        chk("run_k11_state", state_out, 4'hE);
        chk("run_k11_done", done, 0);
        tick();
        chk("run_state", state_out, 4'hF);
        chk("run_done", done, 1);
        chk("run_running", running, 0);
        chk("run_cnt", step_cnt, 12);
        chk("run_timeout", timeout, 0);
        step_req = 1; start = 1;
        tick();
        chk("done_hold_state", state_out, 4'hF);
        chk("done_ign_step", step_ack, 0);
        chk("done_hold", done, 1);
        step_req = 0; start = 0;

        // Load from DONE returns to IDLE
        load = 1; load_val = 4'h0;
        tick();
        load = 0;
        chk("dload_done", done, 0);
        chk("dload_state", state_out, 0);
        chk("dload_cnt", step_cnt, 0);

        // Single step with request held
        step_req = 1;
        tick();
        chk("step_pre_ack", step_ack, 0);
        chk("step_pre_state", state_out, 0);
        tick();
        chk("step_ack", step_ack, 1);
        chk("step_state", state_out, 1);
        repeat (5) tick();
        chk("step_held_state", state_out, 1);
        chk("step_held_cnt", step_cnt, 1);
        chk("step_held_ack", step_ack, 1);
        step_req = 0;
        tick();
        chk("step_rel_ack", step_ack, 0);
        chk("step_rel_done", done, 0);
        chk("step_rel_state", state_out, 1);

        // Step onto the terminal state ends in DONE
        load = 1; load_val = 4'hE;
        tick();
        load = 0; step_req = 1;
        repeat (2) tick();
        chk("stepT_state", state_out, 4'hF);
        step_req = 0;
        tick();
        chk("stepT_done", done, 1);

        // load_val == TERM_STATE does not enter DONE
        load = 1; load_val = 4'hF;
        tick();
        load = 0;
        chk("loadT_state", state_out, 4'hF);
        chk("loadT_done", done, 0);
        tick();
        chk("loadT_done2", done, 0);

        // Asynchronous reset mid-run at state 5
        load = 1; load_val = 4'h0;
        tick();
        load = 0; start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        chk("arst_pre_state", state_out, 5);
        chk("arst_pre_running", running, 1);
        #1 clear_n = 0;
        #1;
        chk("arst_state", state_out, 0);
        chk("arst_running", running, 0);
        chk("arst_cnt", step_cnt, 0);
        tick();
        clear_n = 1;

        // Asynchronous reset mid-handshake drops step_ack
        step_req = 1;
        repeat (2) tick();
        chk("arst_hs_pre", step_ack, 1);
        #1 clear_n = 0;
        #1;
        chk("arst_hs_ack", step_ack, 0);
        step_req = 0;
        tick();
        clear_n = 1;

        // Stop at state 7 freezes state and count
        start = 1;
        tick();
        start = 0;
        repeat (7) tick();
        chk("stop_pre_state", state_out, 7);
        stop = 1;
        tick();
        chk("stop_running", running, 0);
        chk("stop_state", state_out, 7);
        chk("stop_cnt", step_cnt, 7);
        tick();
        chk("stop_state2", state_out, 7);
        chk("stop_cnt2", step_cnt, 7);
        stop = 0;

        // Watchdog: next_in stuck at 2
        load = 1; load_val = 4'h0;
        tick();
        load = 0; ovr = 1; ovr_val = 4'h2; start = 1;
        tick();
        start = 0;
`ifdef SEQ_WATCHDOG_EN
        repeat (15) tick();
        chk("wd_k15_running", running, 1);
        chk("wd_k15_done", done, 0);
        tick();
        chk("wd_done", done, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_running", running, 0);
        chk("wd_cnt", step_cnt, 16);
        load = 1; load_val = 4'h0;
        tick();
        load = 0;
        chk("wd_clear_to", timeout, 0);
        chk("wd_clear_done", done, 0);
`else
        repeat (40) tick();
        chk("nowd_running", running, 1);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_cnt", step_cnt, 40);
        chk("nowd_state", state_out, 2);
        stop = 1;
        tick();
        stop = 0;
        chk("nowd_stop", running, 0);
        load = 1; load_val = 4'h0;
        tick();
        load = 0;
`endif

        // Counter saturation via repeated single steps (state stays 2)
        for (int i = 0; i < 256; i++) begin
            step_req = 1;
            repeat (2) tick();
            step_req = 0;
            tick();
            if (i == 254) chk("sat_255", step_cnt, 255);
        end
        chk("sat_hold", step_cnt, 255);
        chk("sat_state", state_out, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
